// File: rtl/lsu_pkg.sv
// Shared LSU definitions: op encodings, FSM states and op-decoding helpers.
package lsu_pkg;

    localparam int LSU_OP_W = 4;

    typedef enum logic [LSU_OP_W-1:0] {
        LSU_LB  = 4'd0,
        LSU_LH  = 4'd1,
        LSU_LW  = 4'd2,
        LSU_LD  = 4'd3,
        LSU_LBU = 4'd4,
        LSU_LHU = 4'd5,
        LSU_LWU = 4'd6,
        LSU_SB  = 4'd8,
        LSU_SH  = 4'd9,
        LSU_SW  = 4'd10,
        LSU_SD  = 4'd11
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    function automatic logic [1:0] op_size(input logic [LSU_OP_W-1:0] op);
        return op[1:0];
    endfunction

    function automatic logic op_store(input logic [LSU_OP_W-1:0] op);
        return op[3];
    endfunction

    function automatic logic op_legal(input logic [LSU_OP_W-1:0] op);
        logic legal;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
            4'd8, 4'd9, 4'd10, 4'd11: legal = 1'b1;
            default:                  legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic op_aligned(input logic [LSU_OP_W-1:0] op, input logic [2:0] off);
        logic ok;
        case (op[1:0])
            2'd0:    ok = 1'b1;
            2'd1:    ok = (off[0] == 1'b0);
            2'd2:    ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load lane extraction: shift doubleword by byte offset, truncate, extend.
// Zero latency; no handshake.
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [63:0]         dword,
    input  logic [2:0]          offset,
    input  logic [LSU_OP_W-1:0] op,
    output logic [XLEN-1:0]     result
);

    logic [63:0] shifted;

    assign shifted = dword >> {offset, 3'b000};

    always_comb begin
        result = '0;
        case (op)
            LSU_LB:  result = {{56{shifted[7]}},  shifted[7:0]};
            LSU_LH:  result = {{48{shifted[15]}}, shifted[15:0]};
            LSU_LW:  result = {{32{shifted[31]}}, shifted[31:0]};
            LSU_LD:  result = shifted;
            LSU_LBU: result = {56'b0, shifted[7:0]};
            LSU_LHU: result = {48'b0, shifted[15:0]};
            LSU_LWU: result = {32'b0, shifted[31:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit; accept-to-result 3 cycles load, 2 store, 1 error.
// in_ready only in IDLE; bus request held until mem_req_ready; result held until out_ready.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic [LSU_OP_W-1:0] in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_rdata,
    output logic                out_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [7:0]          mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_data
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [LSU_OP_W-1:0]   op_q, op_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [XLEN-1:0]       ext_rdata;

    lsu_load_extend #(.XLEN(XLEN)) u_load_extend (
        .dword  (mem_rsp_data),
        .offset (addr_q[2:0]),
        .op     (op_q),
        .result (ext_rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    op_d    = in_op;
                    rdata_d = '0;
                    err_d   = !op_legal(in_op) || !op_aligned(in_op, in_addr[2:0]);
                    state_d = err_d ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                // Stores are posted: no response is expected.
                if (mem_req_ready) begin
                    state_d = op_store(op_q) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = ext_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign out_rdata     = rdata_q;
    assign out_err       = err_q;
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_req_wen   = op_store(op_q);
    assign mem_req_wdata = wdata_q << {addr_q[2:0], 3'b000};
    assign mem_req_wmask = op_store(op_q) ? (size_mask(op_size(op_q)) << addr_q[2:0]) : 8'h00;

endmodule

// File: tb/tb_lsu.sv
// Directed LSU bench: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_addr = '0;
    logic [63:0] in_wdata = '0;
    logic [3:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_rdata;
    logic        out_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data = '0;

    always #5 clk = ~clk;

    lsu #(.XLEN(64), .ADDR_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_op         (in_op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_err       (out_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        string       name;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  op;
        logic [63:0] rsp;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_wen;
        logic [7:0]  exp_mask;
        logic [63:0] exp_wdata;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: out_valid with rdata %h and no expected entry", out_rdata);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_rdata", out_rdata, mon_e.rdata);
                chk("sb_err", {63'b0, out_err}, {63'b0, mon_e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic add(input string nm, input logic [63:0] a, input logic [63:0] wd,
                       input logic [3:0] op, input logic [63:0] rsp, input logic [63:0] er,
                       input logic ee, input int lat, input logic req, input logic [63:0] ea,
                       input logic ewen, input logic [7:0] em, input logic [63:0] ew);
        vec_t v;
        v.name = nm; v.addr = a; v.wdata = wd; v.op = op; v.rsp = rsp;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_req = req;
        v.exp_addr = ea; v.exp_wen = ewen; v.exp_mask = em; v.exp_wdata = ew;
        vecs.push_back(v);
    endtask

    task automatic txn(input vec_t v);
        exp_t        e;
        int          lat;
        logic        done, req_seen, pend;
        logic [63:0] c_addr, c_wdata;
        logic [7:0]  c_mask;
        logic        c_wen;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b1; in_addr = v.addr; in_wdata = v.wdata; in_op = v.op;
        @(negedge clk);
        chk({v.name, "_in_ready"}, {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; done = 1'b0; req_seen = 1'b0; pend = 1'b0;
        c_addr = '0; c_wdata = '0; c_mask = '0; c_wen = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                done = 1'b1;
            end else begin
                if (mem_req_valid && !req_seen) begin
                    req_seen = 1'b1;
                    c_addr = mem_req_addr; c_wdata = mem_req_wdata;
                    c_mask = mem_req_wmask; c_wen = mem_req_wen;
                end
                pend = mem_req_valid && mem_req_ready && !mem_req_wen;
                @(posedge clk); #1;
                mem_rsp_valid = pend;
                mem_rsp_data  = pend ? v.rsp : 64'hDEAD_BEEF_DEAD_BEEF;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: out_valid not seen within %0d cycles", v.name, lat);
        end
        chk({v.name, "_latency"}, 64'(lat), 64'(v.exp_lat));
        chk({v.name, "_req_seen"}, {63'b0, req_seen}, {63'b0, v.exp_req});
        if (v.exp_req) begin
            chk({v.name, "_addr"}, c_addr, v.exp_addr);
            chk({v.name, "_wen"}, {63'b0, c_wen}, {63'b0, v.exp_wen});
            chk({v.name, "_wmask"}, {56'b0, c_mask}, {56'b0, v.exp_mask});
            chk({v.name, "_wdata"}, c_wdata, v.exp_wdata);
        end
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] h_addr, h_wdata;
        logic [7:0]  h_mask;
        logic        h_wen;

        // Reset values while rst is held
        #2;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_rdata", out_rdata, 64'd0);
        chk("rst_out_err", {63'b0, out_err}, 64'd0);
        chk("rst_req_valid", {63'b0, mem_req_valid}, 64'd0);
        chk("rst_req_wen", {63'b0, mem_req_wen}, 64'd0);
        chk("rst_req_wmask", {56'b0, mem_req_wmask}, 64'd0);
        chk("rst_req_addr", mem_req_addr, 64'd0);
        chk("rst_req_wdata", mem_req_wdata, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        //   name    addr                 wdata                 op     rsp                     exp_rdata              err lat req exp_addr            wen mask   exp_wdata
        add("lb",   64'h8000_0003, 64'h0, 4'd0,  64'h1122_3344_8566_7788, 64'hFFFF_FFFF_FFFF_FF85, 0, 3, 1, 64'h8000_0000, 0, 8'h00, 64'h0);
        add("lbu",  64'h8000_0003, 64'h0, 4'd4,  64'h1122_3344_8566_7788, 64'h0000_0000_0000_0085, 0, 3, 1, 64'h8000_0000, 0, 8'h00, 64'h0);
        add("sh",   64'h8000_0006, 64'hABCD, 4'd9, 64'h0, 64'h0, 0, 2, 1, 64'h8000_0000, 1, 8'hC0, 64'hABCD_0000_0000_0000);
        add("lw_mis", 64'h8000_0002, 64'h0, 4'd2, 64'h0, 64'h0, 1, 1, 0, 64'h0, 0, 8'h00, 64'h0);
        add("op7",  64'h8000_0000, 64'h0, 4'd7,  64'h0, 64'h0, 1, 1, 0, 64'h0, 0, 8'h00, 64'h0);
        add("ld",   64'h8000_0008, 64'h0, 4'd3,  64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 0, 3, 1, 64'h8000_0008, 0, 8'h00, 64'h0);
        add("lwu",  64'h8000_000C, 64'h0, 4'd6,  64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001, 0, 3, 1, 64'h8000_0008, 0, 8'h00, 64'h0);
        add("lw",   64'h8000_000C, 64'h0, 4'd2,  64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 0, 3, 1, 64'h8000_0008, 0, 8'h00, 64'h0);
        add("lhu",  64'h8000_0002, 64'h0, 4'd5,  64'h1122_3344_8566_7788, 64'h0000_0000_0000_8566, 0, 3, 1, 64'h8000_0000, 0, 8'h00, 64'h0);
        add("sb",   64'h8000_0005, 64'h12, 4'd8, 64'h0, 64'h0, 0, 2, 1, 64'h8000_0000, 1, 8'h20, 64'h0000_1200_0000_0000);
        add("sw",   64'h8000_0004, 64'hDEAD_BEEF, 4'd10, 64'h0, 64'h0, 0, 2, 1, 64'h8000_0000, 1, 8'hF0, 64'hDEAD_BEEF_0000_0000);
        add("sd",   64'h8000_0010, 64'h0123_4567_89AB_CDEF, 4'd11, 64'h0, 64'h0, 0, 2, 1, 64'h8000_0010, 1, 8'hFF, 64'h0123_4567_89AB_CDEF);
        add("sd_mis", 64'h8000_0004, 64'h1, 4'd11, 64'h0, 64'h0, 1, 1, 0, 64'h0, 0, 8'h00, 64'h0);
        add("op12", 64'h8000_0000, 64'h1, 4'd12, 64'h0, 64'h0, 1, 1, 0, 64'h0, 0, 8'h00, 64'h0);
        foreach (vecs[i]) txn(vecs[i]);

        // Backpressure on both the bus request and the result
        mon_e.rdata = 64'hFFFF_FFFF_FFFF_8765;
        mon_e.err   = 1'b0;
        sb_q.push_back(mon_e);
        @(posedge clk); #1;
        mem_req_ready = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_addr = 64'h8000_0006; in_wdata = 64'h0; in_op = 4'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        h_addr = mem_req_addr; h_wdata = mem_req_wdata; h_mask = mem_req_wmask; h_wen = mem_req_wen;
        chk("bp_first_addr", h_addr, 64'h8000_0000);
        chk("bp_first_wmask", {56'b0, h_mask}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_req_valid", {63'b0, mem_req_valid}, 64'd1);
            chk("bp_req_addr", mem_req_addr, h_addr);
            chk("bp_req_wdata", mem_req_wdata, h_wdata);
            chk("bp_req_wmask", {56'b0, mem_req_wmask}, {56'b0, h_mask});
            chk("bp_req_wen", {63'b0, mem_req_wen}, {63'b0, h_wen});
            chk("bp_req_in_ready", {63'b0, in_ready}, 64'd0);
        end
        @(posedge clk); #1;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h8765_4321_0000_0000;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0; mem_rsp_data = 64'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
            chk("bp_out_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_8765);
            chk("bp_out_in_ready", {63'b0, in_ready}, 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset while waiting for a load response
        in_valid = 1'b1; in_addr = 64'h8000_0010; in_wdata = 64'h0; in_op = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_in_wait_req_valid", {63'b0, mem_req_valid}, 64'd0);
        chk("rw_in_wait_addr", mem_req_addr, 64'h8000_0010);
        #2;
        rst = 1'b1;
        #1;
        chk("rw_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rw_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rw_req_valid", {63'b0, mem_req_valid}, 64'd0);
        chk("rw_req_addr", mem_req_addr, 64'd0);
        chk("rw_out_rdata", out_rdata, 64'd0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1234_5678_9ABC_DEF0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("stray_out_valid", {63'b0, out_valid}, 64'd0);
        chk("stray_in_ready", {63'b0, in_ready}, 64'd1);
        chk("stray_out_rdata", out_rdata, 64'd0);

        @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
